// File: rtl/multi_port_fifo_if.sv
// Handshake bundle for multi_port_fifo: multi-lane enqueue and dequeue ports plus occupancy.
interface multi_port_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ENQ_LANES  = 2,
    parameter int unsigned DEQ_LANES  = 2
);
    logic [ENQ_LANES-1:0]            valid_enq;
    logic [ENQ_LANES*DATA_WIDTH-1:0] data_enq;
    logic [ENQ_LANES-1:0]            ready_enq;
    logic [DEQ_LANES-1:0]            valid_deq;
    logic [DEQ_LANES-1:0]            ready_deq;
    logic [DEQ_LANES*DATA_WIDTH-1:0] data_deq;
    logic [$clog2(FIFO_DEPTH+1)-1:0] count;

    // Producer/consumer side.
    modport master (
        output valid_enq,
        output data_enq,
        input  ready_enq,
        input  valid_deq,
        output ready_deq,
        input  data_deq,
        input  count
    );

    // FIFO side.
    modport slave (
        input  valid_enq,
        input  data_enq,
        output ready_enq,
        output valid_deq,
        input  ready_deq,
        output data_deq,
        output count
    );
endinterface

// File: rtl/multi_port_fifo.sv
// Circular-buffer FIFO accepting up to ENQ_LANES entries and releasing up to DEQ_LANES
// entries per cycle. Lanes are taken as a contiguous prefix from lane 0; status outputs
// depend on registered occupancy only, so there is no enqueue-to-dequeue bypass.
module multi_port_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ENQ_LANES  = 2,
    parameter int unsigned DEQ_LANES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    multi_port_fifo_if.slave bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned SLOTS = 1 << PTR_W;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [SLOTS];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic [CNT_W-1:0]      w_free;
    logic [CNT_W-1:0]      w_n_enq;
    logic [CNT_W-1:0]      w_n_deq;
    logic                  w_run_enq;
    logic                  w_run_deq;
    logic [PTR_W-1:0]      w_wr_idx [ENQ_LANES];
    logic [PTR_W-1:0]      w_rd_idx [DEQ_LANES];

    // Per-lane space/availability flags from the registered occupancy.
    always_comb begin
        w_free        = CNT_W'(FIFO_DEPTH) - r_count;
        bus.ready_enq = '0;
        bus.valid_deq = '0;
        for (int k = 0; k < ENQ_LANES; k++) begin
            bus.ready_enq[k] = int'(w_free) > k;
        end
        for (int k = 0; k < DEQ_LANES; k++) begin
            bus.valid_deq[k] = int'(r_count) > k;
        end
        bus.count = r_count;
    end

    // Transfer counts: leading ones of the lane handshakes; a gap stops the prefix.
    always_comb begin
        w_n_enq   = '0;
        w_run_enq = 1'b1;
        for (int k = 0; k < ENQ_LANES; k++) begin
            w_run_enq = w_run_enq & bus.valid_enq[k] & bus.ready_enq[k];
            w_n_enq   = w_n_enq + CNT_W'(w_run_enq);
        end
        w_n_deq   = '0;
        w_run_deq = 1'b1;
        for (int k = 0; k < DEQ_LANES; k++) begin
            w_run_deq = w_run_deq & bus.valid_deq[k] & bus.ready_deq[k];
            w_n_deq   = w_n_deq + CNT_W'(w_run_deq);
        end
    end

    // Slot addresses for each lane; pointer arithmetic wraps at the buffer size.
    always_comb begin
        for (int k = 0; k < ENQ_LANES; k++) begin
            w_wr_idx[k] = r_tail + PTR_W'(k);
        end
        for (int k = 0; k < DEQ_LANES; k++) begin
            w_rd_idx[k] = r_head + PTR_W'(k);
        end
    end

    // Dequeue lane k shows entry head+k; lanes beyond the occupancy are don't-care.
    always_comb begin
        bus.data_deq = '0;
        for (int k = 0; k < DEQ_LANES; k++) begin
            bus.data_deq[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_rd_idx[k]];
        end
    end

    // Storage write for accepted lanes; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int k = 0; k < ENQ_LANES; k++) begin
                if (CNT_W'(k) < w_n_enq) begin
                    r_mem[w_wr_idx[k]] <= bus.data_enq[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Pointer and occupancy update; reset and flush both discard everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_n_deq);
            r_tail  <= r_tail + PTR_W'(w_n_enq);
            r_count <= r_count + w_n_enq - w_n_deq;
        end
    end
endmodule

// File: tb/tb_multi_port_fifo.sv
// Bench for multi_port_fifo: directed vectors with hand-computed checks, then a random run,
// with a queue scoreboard comparing every cycle.
module tb_multi_port_fifo;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned EL    = 2;
    localparam int unsigned DL    = 2;

    logic clk;
    logic rst;
    logic flush;

    multi_port_fifo_if #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .ENQ_LANES (EL),
        .DEQ_LANES (DL)
    ) bus ();

    multi_port_fifo #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .ENQ_LANES (EL),
        .DEQ_LANES (DL)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          sb_en  = 1'b0;
    logic [31:0] exp_q [$];
    int          sb_occ;
    int          sb_n_enq;
    int          sb_n_deq;
    bit          sb_run;
    logic [EL-1:0] sb_rdy;
    logic [DL-1:0] sb_vld;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then return just after the active edge.
    task automatic step(input logic [1:0] ve, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] rd, input logic fl, input logic rs);
        bus.valid_enq = ve;
        bus.data_enq  = {d1, d0};
        bus.ready_deq = rd;
        flush         = fl;
        rst           = rs;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: at the falling edge the monitor compares DUT outputs against the golden
    // queue, then accepted dequeues pop and accepted enqueues push for the coming edge.
    always @(negedge clk) begin
        sb_occ = exp_q.size();
        if (sb_en) begin
            sb_rdy = '0;
            sb_vld = '0;
            for (int k = 0; k < EL; k++) sb_rdy[k] = (DEPTH - sb_occ) > k;
            for (int k = 0; k < DL; k++) sb_vld[k] = sb_occ > k;
            cmp("sb_count", 32'(bus.count), 32'(sb_occ));
            cmp("sb_ready_enq", 32'(bus.ready_enq), 32'(sb_rdy));
            cmp("sb_valid_deq", 32'(bus.valid_deq), 32'(sb_vld));
            for (int k = 0; k < DL; k++) begin
                if (k < sb_occ) cmp("sb_data_deq", bus.data_deq[k*DW +: DW], exp_q[k]);
            end
        end
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            sb_n_deq = 0;
            sb_run   = 1'b1;
            for (int k = 0; k < DL; k++) begin
                sb_run = sb_run && (k < sb_occ) && bus.ready_deq[k];
                if (sb_run) sb_n_deq++;
            end
            sb_n_enq = 0;
            sb_run   = 1'b1;
            for (int k = 0; k < EL; k++) begin
                sb_run = sb_run && ((DEPTH - sb_occ) > k) && bus.valid_enq[k];
                if (sb_run) sb_n_enq++;
            end
            for (int k = 0; k < sb_n_deq; k++) void'(exp_q.pop_front());
            for (int k = 0; k < sb_n_enq; k++) exp_q.push_back(bus.data_enq[k*DW +: DW]);
        end
    end

    initial begin
        bus.valid_enq = '0;
        bus.data_enq  = '0;
        bus.ready_deq = '0;
        flush         = 1'b0;
        rst           = 1'b1;

        // Reset state.
        step(2'b00, 0, 0, 2'b00, 1'b0, 1'b1);
        sb_en = 1'b1;
        cmp("rst_count", 32'(bus.count), 0);
        cmp("rst_valid_deq", 32'(bus.valid_deq), 0);
        cmp("rst_ready_enq", 32'(bus.ready_enq), 3);

        // Two-lane enqueue visible next cycle.
        step(2'b11, 32'h0000_000A, 32'h0000_000B, 2'b00, 1'b0, 1'b0);
        cmp("ab_count", 32'(bus.count), 2);
        cmp("ab_valid_deq", 32'(bus.valid_deq), 3);
        cmp("ab_lane0", bus.data_deq[31:0], 32'h0000_000A);
        cmp("ab_lane1", bus.data_deq[63:32], 32'h0000_000B);

        // Lane-0 gaps block both enqueue and dequeue.
        step(2'b10, 32'h0000_00EE, 32'h0000_00EF, 2'b10, 1'b0, 1'b0);
        cmp("gap_count", 32'(bus.count), 2);
        cmp("gap_lane0", bus.data_deq[31:0], 32'h0000_000A);
        step(2'b00, 0, 0, 2'b11, 1'b0, 1'b0);
        cmp("drain_count", 32'(bus.count), 0);

        // Fill to full, with a single-lane accept at count 7.
        step(2'b11, 0, 1, 2'b00, 1'b0, 1'b0);
        step(2'b11, 2, 3, 2'b00, 1'b0, 1'b0);
        step(2'b11, 4, 5, 2'b00, 1'b0, 1'b0);
        cmp("fill6_count", 32'(bus.count), 6);
        step(2'b01, 6, 77, 2'b00, 1'b0, 1'b0);
        cmp("c7_count", 32'(bus.count), 7);
        cmp("c7_ready_enq", 32'(bus.ready_enq), 1);
        step(2'b11, 7, 99, 2'b00, 1'b0, 1'b0);
        cmp("full_count", 32'(bus.count), 8);
        cmp("full_ready_enq", 32'(bus.ready_enq), 0);
        step(2'b11, 55, 56, 2'b00, 1'b0, 1'b0);
        cmp("full_hold_count", 32'(bus.count), 8);
        cmp("full_hold_lane0", bus.data_deq[31:0], 0);

        // Full with both sides active: only dequeue happens, then steady wrap-around.
        step(2'b11, 100, 101, 2'b11, 1'b0, 1'b0);
        cmp("fulldq_count", 32'(bus.count), 6);
        cmp("fulldq_lane0", bus.data_deq[31:0], 2);
        cmp("fulldq_lane1", bus.data_deq[63:32], 3);
        step(2'b11, 8, 9, 2'b11, 1'b0, 1'b0);
        cmp("wrap_count", 32'(bus.count), 6);
        cmp("wrap_lane0", bus.data_deq[31:0], 4);
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 32'(10 + 2 * i), 32'(11 + 2 * i), 2'b11, 1'b0, 1'b0);
            cmp("wrap_loop_count", 32'(bus.count), 6);
        end
        for (int i = 0; i < 3; i++) begin
            cmp("order_lane0", bus.data_deq[31:0], 32'(10 + 2 * i));
            cmp("order_lane1", bus.data_deq[63:32], 32'(11 + 2 * i));
            step(2'b00, 0, 0, 2'b11, 1'b0, 1'b0);
        end
        cmp("order_empty", 32'(bus.count), 0);

        // Flush at count 5 discards contents and same-cycle enqueues.
        step(2'b11, 20, 21, 2'b00, 1'b0, 1'b0);
        step(2'b11, 22, 23, 2'b00, 1'b0, 1'b0);
        step(2'b01, 24, 0, 2'b00, 1'b0, 1'b0);
        cmp("c5_count", 32'(bus.count), 5);
        step(2'b11, 88, 89, 2'b11, 1'b1, 1'b0);
        cmp("flush_count", 32'(bus.count), 0);
        cmp("flush_valid_deq", 32'(bus.valid_deq), 0);
        step(2'b11, 30, 31, 2'b00, 1'b0, 1'b0);
        cmp("postflush_count", 32'(bus.count), 2);
        cmp("postflush_lane0", bus.data_deq[31:0], 30);
        cmp("postflush_lane1", bus.data_deq[63:32], 31);

        // Reset together with flush mid-operation.
        step(2'b11, 90, 91, 2'b01, 1'b1, 1'b1);
        cmp("midrst_count", 32'(bus.count), 0);
        cmp("midrst_valid_deq", 32'(bus.valid_deq), 0);
        cmp("midrst_ready_enq", 32'(bus.ready_enq), 3);
        step(2'b01, 40, 0, 2'b00, 1'b0, 1'b0);
        cmp("postrst_count", 32'(bus.count), 1);
        cmp("postrst_valid_deq", 32'(bus.valid_deq), 1);
        cmp("postrst_lane0", bus.data_deq[31:0], 40);

        // Random traffic checked by the scoreboard alone.
        for (int i = 0; i < 10000; i++) begin
            step(2'($urandom), $urandom, $urandom, 2'($urandom),
                 $urandom_range(0, 63) == 0, $urandom_range(0, 255) == 0);
        end
        step(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_port_fifo.md
MULTI_PORT_FIFO -- requirements
Module: multi_port_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one entry.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entry count; power of 2 and >= max(ENQ_LANES, DEQ_LANES).
REQ-003 SHALL have parameter ENQ_LANES, default 2, entries enqueueable per cycle.
REQ-004 SHALL have parameter DEQ_LANES, default 2, entries dequeueable per cycle.
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents, active-high.
REQ-008 SHALL have port valid_enq  input  ENQ_LANES  per-lane enqueue request.
REQ-009 SHALL have port data_enq  input  ENQ_LANES*DATA_WIDTH  lane k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port ready_enq  output  ENQ_LANES  per-lane space available.
REQ-011 SHALL have port valid_deq  output  DEQ_LANES  per-lane entry available.
REQ-012 SHALL have port ready_deq  input  DEQ_LANES  per-lane consumer accept.
REQ-013 SHALL have port data_deq  output  DEQ_LANES*DATA_WIDTH  lane k = entry head+k, same packing as data_enq.
REQ-014 SHALL have port count  output  $clog2(FIFO_DEPTH+1)  current occupancy.

Function
REQ-015 ready_enq[k] SHALL be 1 iff (FIFO_DEPTH - count) > k; combinational from registered state only, no dependence on same-cycle dequeue.
REQ-016 valid_deq[k] SHALL be 1 iff count > k; combinational from registered state only, no enqueue-to-dequeue bypass.
REQ-017 Enqueue count n_enq SHALL equal number of leading ones (from lane 0) of valid_enq & ready_enq; lanes after first zero ignored even if valid.
REQ-018 Dequeue count n_deq SHALL equal number of leading ones (from lane 0) of valid_deq & ready_deq; lanes after first zero not consumed.
REQ-019 Accepted lanes 0..n_enq-1 SHALL be written in lane order to slots tail, tail+1, ... modulo FIFO_DEPTH.
REQ-020 Each cycle: head += n_deq, tail += n_enq, count += n_enq - n_deq, pointers wrap modulo FIFO_DEPTH.
REQ-021 Simultaneous enqueue and dequeue SHALL both take effect same cycle; full FIFO still accepts nothing that cycle (REQ-015).
REQ-022 Data written at cycle t SHALL appear on data_deq no earlier than cycle t+1 (latency 1).
REQ-023 FIFO order SHALL be strict: entries leave in exactly the order accepted, across lanes and across cycles.
REQ-024 data_deq lanes with valid_deq[k]=0 SHALL be don't-care.
REQ-025 flush=1 SHALL set head, tail, count to 0 at next edge, discarding same-cycle enqueues and dequeues; storage contents need not clear.
REQ-026 count SHALL never exceed FIFO_DEPTH nor underflow below 0 under any input pattern.

Reset
REQ-027 rst=1 SHALL, at next rising edge, set head=0, tail=0, count=0, overriding flush, enqueue and dequeue.
REQ-028 After reset: valid_deq all 0, ready_enq all 1, count 0; storage not reset.
REQ-029 Reset asserted mid-operation SHALL discard all contents; first post-reset enqueue lands in slot 0.

Verification (DEPTH=8, ENQ_LANES=2, DEQ_LANES=2, DATA_WIDTH=32)
REQ-030 Reset, then enq lanes {A,B} one cycle, no deq -> next cycle count=2, valid_deq=2'b11, data_deq lane0=A, lane1=B.
REQ-031 Enq 2/cycle for 4 cycles, no deq -> count=8, ready_enq=2'b00; further valid_enq=2'b11 changes nothing; at count=7 ready_enq=2'b01 and only lane 0 accepted.
REQ-032 valid_enq=2'b10 (lane 0 idle) -> nothing accepted, count unchanged; ready_deq=2'b10 with 2 entries -> nothing dequeued.
REQ-033 Full FIFO, valid_enq=2'b11, ready_deq=2'b11 -> no enqueue, 2 dequeued, count=6; next cycle enq+deq 2 each -> count stays 6, pointers wrap past slot 7 with order preserved (sequence 0..N checked on output).
REQ-034 count=5, flush=1 with valid_enq=2'b11 -> next cycle count=0, valid_deq=2'b00; rst=1 with flush=1 -> same result; enq after reset/flush returns new data first.
REQ-035 10000-cycle random valid/ready/data/flush bench SHALL compare valid_deq, ready_enq, count every cycle and data_deq on valid lanes against a queue-based golden model.
